vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_timing_gen_pix_div.sv | 27 ++
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and 12-bit colour constants for the
// VGA timing generator and the pixel painter.
package vga_timing_pkg;

  localparam int unsigned CLK_DIV_DEF     = 4;
  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_ACT_START_DEF = 144;
  localparam int unsigned H_ACT_END_DEF   = 784;
  localparam int unsigned V_TOTAL_DEF     = 525;
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_ACT_START_DEF = 35;
  localparam int unsigned V_ACT_END_DEF   = 515;

  localparam int unsigned CNT_W = 10;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] BLUE  = 12'h00F;

  function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_div.sv
// vga_pix_div: one-clk enable strobe every CLK_DIV clocks, for any block that
// needs a pixel-rate enable without a derived clock.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DIV_LAST) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign pix_en = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, registered sync/bright decode and line/frame
// strobes. Optional frame_count output enabled by macro VGA_FRAME_COUNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_ACT_START = H_ACT_START_DEF,
  parameter int unsigned H_ACT_END   = H_ACT_END_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_ACT_START = V_ACT_START_DEF,
  parameter int unsigned V_ACT_END   = V_ACT_END_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        line_start,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0] frame_count,
`endif
  output logic        frame_start
);
  localparam logic [9:0] H_LAST   = to_cnt(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = to_cnt(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = to_cnt(H_SYNC);
  localparam logic [9:0] V_SYNC_C = to_cnt(V_SYNC);
  localparam logic [9:0] H_ACT_S  = to_cnt(H_ACT_START);
  localparam logic [9:0] H_ACT_E  = to_cnt(H_ACT_END);
  localparam logic [9:0] V_ACT_S  = to_cnt(V_ACT_START);
  localparam logic [9:0] V_ACT_E  = to_cnt(V_ACT_END);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic       bright_q, bright_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic       ls_q, ls_d, fs_q, fs_d;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en)
  );

  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d  = '0;
        ls_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Decode from next-state counts so the registered outputs line up with them.
    hs_d     = (h_d >= H_SYNC_C);
    vs_d     = (v_d >= V_SYNC_C);
    bright_d = (h_d >= H_ACT_S) && (h_d < H_ACT_E) &&
               (v_d >= V_ACT_S) && (v_d < V_ACT_E);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      bright_q <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      bright_q <= bright_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (fs_d) fc_d = fc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) fc_q <= '0;
    else       fc_q <= fc_d;
  end

  assign frame_count = fc_q;
`endif

  assign hCount      = h_q;
  assign vCount      = v_q;
  assign bright      = bright_q;
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
